// File: rtl/irq_pkg.sv
// Shared definitions for the vectored interrupt controller: FSM state
// encoding, default cause base and the supported source-count ceiling.
package irq_pkg;

  localparam int unsigned     MAX_N_IRQ          = 32;
  localparam logic [31:0]     DEFAULT_CAUSE_BASE = 32'h1000_0010;

  // IRQ_EXC is an exception taken while an interrupt handler is running.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXC     = 2'd1,
    ST_IRQ     = 2'd2,
    ST_IRQ_EXC = 2'd3
  } irq_state_e;

endpackage

// File: rtl/irq_prio_arbiter.sv
// Fixed-priority arbiter: the lowest set index of the eligible vector wins.
module irq_prio_arbiter #(
  parameter int unsigned N     = 16,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     eligible_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     onehot_o
);

  // NOTE: every output of an always_comb gets a default before any branch,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    idx_o = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (eligible_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign valid_o  = |eligible_i;
  // Two's-complement trick isolates the lowest set bit.
  assign onehot_o = eligible_i & (~eligible_i + N'(1));

endmodule

// File: rtl/irq_vec_controller.sv
// Vectored interrupt controller: level/edge pending capture, fixed-priority
// selection and a four-state handler tracker for interrupts and exceptions.
module irq_vec_controller
  import irq_pkg::*;
#(
  parameter int unsigned       N_IRQ      = 16,
  parameter logic [N_IRQ-1:0]  EDGE_MASK  = '0,
  parameter logic [31:0]       CAUSE_BASE = DEFAULT_CAUSE_BASE
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             exception_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [N_IRQ-1:0] mask_i,
  input  logic             mie_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      irq_cause_o,
  output logic [N_IRQ-1:0] irq_ack_o,
  output logic             irq_ret_o
);

  localparam int unsigned IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  irq_state_e       state_q, state_d;
  logic [N_IRQ-1:0] prev_q, edge_pend_q, edge_pend_d;
  logic [31:0]      cause_q, cause_d;

  logic [N_IRQ-1:0] pending, eligible, win_onehot;
  logic [IDX_W-1:0] win_idx;
  logic             win_valid, take;
  logic [31:0]      win_cause;

  assign pending  = (edge_pend_q & EDGE_MASK) | (irq_req_i & ~EDGE_MASK);
  assign eligible = pending & mask_i & {N_IRQ{mie_i}};

  irq_prio_arbiter #(.N(N_IRQ), .IDX_W(IDX_W)) u_arb (
    .eligible_i (eligible),
    .valid_o    (win_valid),
    .idx_o      (win_idx),
    .onehot_o   (win_onehot)
  );

  // Outputs are gated by rst_ni so they sit at reset values while reset is held.
  assign take        = rst_ni && (state_q == ST_IDLE) && !exception_i && win_valid;
  assign win_cause   = CAUSE_BASE + {{(32 - IDX_W){1'b0}}, win_idx};
  assign irq_o       = take;
  assign irq_ack_o   = take ? win_onehot : '0;
  assign irq_cause_o = take ? win_cause : cause_q;
  assign irq_ret_o   = rst_ni && (state_q == ST_IRQ) && mret_i && !exception_i;

  // A new rising edge on the claim cycle re-arms the bit (set beats clear).
  assign edge_pend_d = ((edge_pend_q & ~irq_ack_o) | (irq_req_i & ~prev_q)) & EDGE_MASK;

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      ST_IDLE: begin
        if (exception_i) begin
          state_d = ST_EXC;
        end else if (take) begin
          state_d = ST_IRQ;
          cause_d = win_cause;
        end
      end
      ST_EXC: begin
        if (!exception_i && mret_i) state_d = ST_IDLE;
      end
      ST_IRQ: begin
        if (exception_i)  state_d = ST_IRQ_EXC;
        else if (mret_i)  state_d = ST_IDLE;
      end
      ST_IRQ_EXC: begin
        if (!exception_i && mret_i) state_d = ST_IRQ;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      prev_q      <= '0;
      edge_pend_q <= '0;
      cause_q     <= CAUSE_BASE;
    end else begin
      state_q     <= state_d;
      prev_q      <= irq_req_i;
      edge_pend_q <= edge_pend_d;
      cause_q     <= cause_d;
    end
  end

endmodule

// File: tb/tb_irq_vec_controller.sv
// Directed bench for irq_vec_controller: a combinational vector table in IDLE
// plus hand-written multi-cycle sequences for nesting, edges and reset.
module tb_irq_vec_controller;

  localparam int unsigned N = 16;
  localparam logic [31:0] BASE = 32'h1000_0010;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          exception_i;
  logic [N-1:0]  irq_req_i;
  logic [N-1:0]  mask_i;
  logic          mie_i;
  logic          mret_i;
  logic          irq_o;
  logic [31:0]   irq_cause_o;
  logic [N-1:0]  irq_ack_o;
  logic          irq_ret_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] mask;
    logic         mie;
    logic         exc;
    logic         exp_irq;
    logic [N-1:0] exp_ack;
    logic [31:0]  exp_cause;
  } vec_t;

  vec_t vecs [10];

  irq_vec_controller #(
    .N_IRQ      (N),
    .EDGE_MASK  (16'h0020),
    .CAUSE_BASE (BASE)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .exception_i (exception_i),
    .irq_req_i   (irq_req_i),
    .mask_i      (mask_i),
    .mie_i       (mie_i),
    .mret_i      (mret_i),
    .irq_o       (irq_o),
    .irq_cause_o (irq_cause_o),
    .irq_ack_o   (irq_ack_o),
    .irq_ret_o   (irq_ret_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic outs(input string name, input logic e_irq, input logic [N-1:0] e_ack,
                      input logic [31:0] e_cause, input logic e_ret);
    #1;
    check({name, ".irq"},   32'(irq_o),     32'(e_irq));
    check({name, ".ack"},   32'(irq_ack_o), 32'(e_ack));
    check({name, ".cause"}, irq_cause_o,    e_cause);
    check({name, ".ret"},   32'(irq_ret_o), 32'(e_ret));
  endtask

  initial begin
    vecs[0] = '{16'h0088, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0008, 32'h1000_0013};
    vecs[1] = '{16'h0088, 16'hFFF7, 1'b1, 1'b0, 1'b1, 16'h0080, 32'h1000_0017};
    vecs[2] = '{16'h0088, 16'hFFFF, 1'b0, 1'b0, 1'b0, 16'h0000, 32'h1000_0010};
    vecs[3] = '{16'h8000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h8000, 32'h1000_001F};
    vecs[4] = '{16'h0001, 16'hFFFF, 1'b1, 1'b1, 1'b0, 16'h0000, 32'h1000_0010};
    vecs[5] = '{16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h1000_0010};
    vecs[6] = '{16'h0020, 16'hFFFF, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h1000_0010};
    vecs[7] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 32'h1000_0010};
    vecs[8] = '{16'hFFFF, 16'h0400, 1'b1, 1'b0, 1'b1, 16'h0400, 32'h1000_001A};
    vecs[9] = '{16'h0021, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0001, 32'h1000_0010};

    // Reset held with every source requesting: outputs must stay quiet.
    rst_ni = 1'b0; exception_i = 1'b0; mret_i = 1'b1;
    irq_req_i = 16'hFFFF; mask_i = 16'hFFFF; mie_i = 1'b1;
    #12;
    outs("reset", 1'b0, 16'h0000, BASE, 1'b0);
    irq_req_i = '0; mret_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Combinational vectors in IDLE; inputs withdrawn before each edge.
    for (int i = 0; i < 10; i++) begin
      irq_req_i = vecs[i].req; mask_i = vecs[i].mask;
      mie_i = vecs[i].mie; exception_i = vecs[i].exc;
      outs($sformatf("vec%0d", i), vecs[i].exp_irq, vecs[i].exp_ack, vecs[i].exp_cause, 1'b0);
      irq_req_i = '0; exception_i = 1'b0; mask_i = 16'hFFFF; mie_i = 1'b1;
      tick();
    end

    // Level 3 and 7: take 3, return, take 3 again.
    irq_req_i = 16'h0088;
    outs("lvl.take", 1'b1, 16'h0008, 32'h1000_0013, 1'b0);
    tick();
    outs("lvl.insvc", 1'b0, 16'h0000, 32'h1000_0013, 1'b0);
    mret_i = 1'b1;
    outs("lvl.mret", 1'b0, 16'h0000, 32'h1000_0013, 1'b1);
    tick();
    mret_i = 1'b0;
    outs("lvl.retake", 1'b1, 16'h0008, 32'h1000_0013, 1'b0);
    tick();
    mret_i = 1'b1; irq_req_i = '0;
    tick();
    mret_i = 1'b0;

    // Exception beats a simultaneous level-0 request.
    irq_req_i = 16'h0001; exception_i = 1'b1;
    outs("exc.win", 1'b0, 16'h0000, 32'h1000_0013, 1'b0);
    tick();
    exception_i = 1'b0;
    outs("exc.inexc", 1'b0, 16'h0000, 32'h1000_0013, 1'b0);
    mret_i = 1'b1;
    outs("exc.mret", 1'b0, 16'h0000, 32'h1000_0013, 1'b0);
    tick();
    mret_i = 1'b0;
    outs("exc.after", 1'b1, 16'h0001, 32'h1000_0010, 1'b0);
    tick();
    irq_req_i = '0;

    // Nested exception inside the handler, then two returns.
    exception_i = 1'b1;
    tick();
    exception_i = 1'b0; mret_i = 1'b1;
    outs("nest.mret1", 1'b0, 16'h0000, 32'h1000_0010, 1'b0);
    tick();
    outs("nest.mret2", 1'b0, 16'h0000, 32'h1000_0010, 1'b1);
    tick();
    outs("nest.idle_mret", 1'b0, 16'h0000, 32'h1000_0010, 1'b0);
    tick();
    mret_i = 1'b0; irq_req_i = 16'h0001;
    outs("nest.idle", 1'b1, 16'h0001, 32'h1000_0010, 1'b0);
    tick();
    irq_req_i = '0; exception_i = 1'b1; mret_i = 1'b1;
    outs("nest.both", 1'b0, 16'h0000, 32'h1000_0010, 1'b0);
    tick();
    exception_i = 1'b0;
    outs("nest.both_exc", 1'b0, 16'h0000, 32'h1000_0010, 1'b0);
    tick();
    outs("nest.both_irq", 1'b0, 16'h0000, 32'h1000_0010, 1'b1);
    tick();
    mret_i = 1'b0;

    // Edge source 5 pulsed while in service, taken on return, re-armed once.
    irq_req_i = 16'h0001;
    tick();
    irq_req_i = 16'h0020;
    tick();
    irq_req_i = '0;
    tick();
    outs("edge.held", 1'b0, 16'h0000, 32'h1000_0010, 1'b0);
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0; irq_req_i = 16'h0020;
    outs("edge.take", 1'b1, 16'h0020, 32'h1000_0015, 1'b0);
    tick();
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    outs("edge.rearm", 1'b1, 16'h0020, 32'h1000_0015, 1'b0);
    tick();
    mret_i = 1'b1;
    tick();
    mret_i = 1'b0;
    outs("edge.none", 1'b0, 16'h0000, 32'h1000_0015, 1'b0);
    irq_req_i = '0;
    tick();

    // Global and per-source enables release the request combinationally.
    irq_req_i = 16'h0004; mie_i = 1'b0;
    outs("en.mie0", 1'b0, 16'h0000, 32'h1000_0015, 1'b0);
    mie_i = 1'b1;
    outs("en.mie1", 1'b1, 16'h0004, 32'h1000_0012, 1'b0);
    mask_i = 16'hFFFB;
    outs("en.mask0", 1'b0, 16'h0000, 32'h1000_0015, 1'b0);
    mask_i = 16'hFFFF;
    outs("en.mask1", 1'b1, 16'h0004, 32'h1000_0012, 1'b0);
    irq_req_i = '0;
    tick();

    // Reset asserted mid-cycle while in IRQ_EXC.
    irq_req_i = 16'h0002;
    tick();
    irq_req_i = '0; exception_i = 1'b1;
    tick();
    exception_i = 1'b0; mret_i = 1'b1;
    outs("rst.irqexc", 1'b0, 16'h0000, 32'h1000_0011, 1'b0);
    irq_req_i = 16'h0002; rst_ni = 1'b0;
    outs("rst.async", 1'b0, 16'h0000, BASE, 1'b0);
    mret_i = 1'b0; rst_ni = 1'b1;
    outs("rst.idle", 1'b1, 16'h0002, 32'h1000_0011, 1'b0);
    irq_req_i = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/irq_vec_controller.md
IRQ_VEC_CONTROLLER -- requirements
Module: irq_vec_controller

Interface
REQ-001 Parameter N_IRQ, default 16, number of interrupt sources, legal range 1..32.
REQ-002 Parameter EDGE_MASK, N_IRQ bits, default all 0; bit k=1 makes source k edge-triggered, 0 makes it level-triggered.
REQ-003 Parameter CAUSE_BASE, 32 bits, default 32'h1000_0010; cause code of source 0.
REQ-004 clk_i  in  1  single clock; all state updates on rising edge.
REQ-005 rst_ni  in  1  asynchronous reset, active-low.
REQ-006 exception_i  in  1  synchronous exception raised by the core this cycle.
REQ-007 irq_req_i  in  N_IRQ  per-source interrupt request lines.
REQ-008 mask_i  in  N_IRQ  per-source enable; 1 = source eligible.
REQ-009 mie_i  in  1  global interrupt enable.
REQ-010 mret_i  in  1  core executes MRET this cycle.
REQ-011 irq_o  out  1  one-cycle pulse: interrupt taken.
REQ-012 irq_cause_o  out  32  cause code of the taken or in-service interrupt.
REQ-013 irq_ack_o  out  N_IRQ  one-hot claim pulse to the source; asserted with irq_o.
REQ-014 irq_ret_o  out  1  MRET returns from an interrupt handler; not asserted for an exception return.

Function
REQ-015 FSM states SHALL be IDLE, EXC, IRQ and IRQ_EXC (exception nested inside an interrupt handler).
REQ-016 Pending vector: level source k pending = irq_req_i[k]; edge source k pending bit set on a 0->1 transition of irq_req_i[k] (previous-value register), cleared on claim of k; simultaneous set and clear -> set wins.
REQ-017 Eligible = pending & mask_i & {N_IRQ{mie_i}}; the winner is the lowest eligible index (fixed priority).
REQ-018 IDLE: exception_i=1 -> EXC, irq_o=0 even if a source is eligible (exception wins).
REQ-019 IDLE, exception_i=0, eligible nonzero -> irq_o=1 and irq_ack_o=onehot(winner) combinationally in the same cycle; cause_q <= CAUSE_BASE+winner; next state IRQ.
REQ-020 EXC: mret_i -> IDLE, irq_ret_o=0; exception_i while in EXC -> stay in EXC.
REQ-021 IRQ: exception_i -> IRQ_EXC; otherwise mret_i -> IDLE with irq_ret_o=1 the same cycle; exception_i and mret_i together -> IRQ_EXC, irq_ret_o=0.
REQ-022 IRQ_EXC: mret_i -> IRQ, irq_ret_o=0.
REQ-023 No interrupt SHALL be taken outside IDLE: irq_o=0 and irq_ack_o=0 in EXC, IRQ and IRQ_EXC; edge pending bits keep accumulating.
REQ-024 irq_cause_o = CAUSE_BASE+winner while irq_o=1, otherwise cause_q; addition is 32-bit modulo 2^32.
REQ-025 mret_i in IDLE SHALL be ignored: no state change, irq_ret_o=0.

Reset
REQ-026 On rst_ni=0, asynchronously: state=IDLE, edge pending=0, previous-request register=0, cause_q=CAUSE_BASE.
REQ-027 Reset outputs: irq_o=0, irq_ack_o=0, irq_ret_o=0, irq_cause_o=CAUSE_BASE.
REQ-028 Reset mid-handler SHALL abandon the handler; the first cycle after release is IDLE and may take an interrupt.

Structure
REQ-029 Package irq_pkg SHALL hold the state enum, the default CAUSE_BASE and the N_IRQ upper limit.
REQ-030 Sub-module irq_prio_arbiter: N_IRQ-bit eligible in -> valid, index ($clog2 width, minimum 1), one-hot; purely combinational.

Verification
REQ-031 Level sources 3 and 7 high, mask all 1, mie=1 in IDLE -> irq_o pulse, irq_ack_o=0x0008, irq_cause_o=0x1000_0013; after mret, irq_ret_o=1, then source 3 is taken again if still high.
REQ-032 exception_i and level source 0 request in the same IDLE cycle -> irq_o=0, state EXC; mret gives irq_ret_o=0; next cycle irq_o=1 with cause 0x1000_0010.
REQ-033 In IRQ: exception_i, then mret -> irq_ret_o=0, state IRQ; second mret -> irq_ret_o=1, state IDLE.
REQ-034 Edge source 5 (EDGE_MASK bit 5=1) pulsed one cycle during IRQ -> held pending; after return, irq_o=1, cause 0x1000_0015; with no new edge, no second irq.
REQ-035 mie_i=0 or mask_i[k]=0 with request k high -> no irq_o; raising the enable -> irq_o in the same cycle.
REQ-036 rst_ni asserted in IRQ_EXC between clock edges -> all outputs at reset values immediately; IDLE after release.
